// File: rtl/pix_pipe_pkg.sv
// Shared types for the per-pixel colour pipeline controller.
package pix_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_Y      = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_BLACK  = 2'd2,
    MODE_TEST   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_SEEK,
    S_VBLANK,
    S_ACTIVE
  } state_t;

  // v marks a slot filled since reset, so flushed zeros are never mistaken for a real low vsync.
  typedef struct packed {
    logic v;
    logic dv;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/pix_pipe_ctrl_sync_delay.sv
// Generic shift register; exposes the output stage and the stage about to become the output.
module sync_delay #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] last,
  output logic [W-1:0] prev
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this is a short flop chain, not a RAM, so every stage is cleared and no stale sync survives reset.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take its neighbour's old value, giving a true shift.
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign last = stage[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_single
      assign prev = din;
    end else begin : g_chain
      assign prev = stage[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/pix_pipe_ctrl.sv
// Delays the sync group by the datapath latency, tracks geometry on the delayed stream
// and applies mode changes only at frame boundaries.
module pix_pipe_ctrl
  import pix_pipe_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int H_VISIBLE = 64,
  parameter int V_VISIBLE = 64,
  parameter int XW        = $clog2(H_VISIBLE+1),
  parameter int YW        = $clog2(V_VISIBLE+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dv_i,
  input  logic          hs_i,
  input  logic          vs_i,
  input  logic          cfg_wr_i,
  input  logic [1:0]    cfg_mode_i,
  output logic          dv_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          line_end_o,
  output logic          frame_start_o,
  output logic [1:0]    mode_o,
  output logic          cfg_busy_o,
  output logic          err_o
);

  localparam logic [XW-1:0] X_LAST = XW'(H_VISIBLE-1);
  localparam logic [XW-1:0] X_MAX  = '1;
  localparam logic [YW-1:0] Y_FULL = YW'(V_VISIBLE);
  localparam logic [YW-1:0] Y_MAX  = '1;

  sync_t         din, last, prev;
  state_t        state;
  mode_t         mode_q, pend_q;
  logic          vs_q, armed, busy_q, err_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          frame_start, line_end;
  logic          unused_prev;

  assign din = '{v: 1'b1, dv: dv_i, hs: hs_i, vs: vs_i};

  sync_delay #(.W($bits(sync_t)), .DEPTH(LATENCY)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .last (last),
    .prev (prev)
  );

  assign unused_prev = ^{prev.v, prev.hs, prev.vs};

  // A rise only counts once a genuine low vsync has left the delay line since reset.
  assign frame_start = armed & last.vs & ~vs_q;
  assign line_end    = (state != S_SEEK) & last.dv & ~prev.dv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_SEEK;
      vs_q   <= 1'b0;
      armed  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      err_q  <= 1'b0;
      mode_q <= MODE_Y;
      pend_q <= MODE_Y;
      busy_q <= 1'b0;
    end else begin
      vs_q  <= last.vs;
      armed <= armed | (last.v & ~last.vs);

      case (state)
        S_SEEK:   if (frame_start) state <= S_VBLANK;
        S_VBLANK: if (!frame_start && last.dv) state <= S_ACTIVE;
        S_ACTIVE: if (frame_start) state <= S_VBLANK;
        default:  state <= S_SEEK;
      endcase

      if (state != S_SEEK) begin
        if (frame_start) begin
          x_q <= '0;
          y_q <= '0;
        end else begin
          if (last.dv) x_q <= line_end ? '0 : ((x_q == X_MAX) ? x_q : x_q + 1'b1);
          if (line_end && state == S_ACTIVE && y_q != Y_MAX) y_q <= y_q + 1'b1;
        end
      end

      // The frame_start clear and that frame's own line-count check land in the same cycle.
      err_q <= (err_q & ~frame_start)
             | (frame_start & (state == S_ACTIVE) & (y_q != Y_FULL))
             | (line_end & (x_q != X_LAST));

      if (cfg_wr_i && (frame_start || state == S_SEEK)) begin
        mode_q <= mode_t'(cfg_mode_i);
        busy_q <= 1'b0;
      end else if (cfg_wr_i) begin
        pend_q <= mode_t'(cfg_mode_i);
        busy_q <= 1'b1;
      end else if (frame_start && busy_q) begin
        mode_q <= pend_q;
        busy_q <= 1'b0;
      end
    end
  end

  assign dv_o          = last.dv;
  assign hs_o          = last.hs;
  assign vs_o          = last.vs;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_end_o    = line_end;
  assign frame_start_o = frame_start;
  assign mode_o        = mode_q;
  assign cfg_busy_o    = busy_q;
  assign err_o         = err_q;

endmodule
